pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Consumes the asynchronous `locked` flag from the board PLL and runs in the PLL's 125 MHz output clock domain.
- Synchronises and qualifies lock, then releases two staged active-low resets: core logic first, then the panel driver.
- Monitors loss of lock, re-asserts both resets immediately when lock drops, and keeps a saturating loss-of-lock event counter for debug readout.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before core reset release; must be >= 1.
- STAGE_DELAY, 16: cycles between core reset release and panel reset release; must be >= 1.
- LOSS_CNT_W, 8: width of the loss-of-lock counter.

Ports:
- clock  in  1  125 MHz system clock (PLL CLKOP).
- reset_n  in  1  asynchronous active-low reset.
- locked  in  1  PLL LOCK; asynchronous to clock; may glitch.
- clear_loss  in  1  synchronous pulse; clears loss_count.
- core_reset_n  out  1  active-low reset for core logic.
- panel_reset_n  out  1  active-low reset for panel driver logic.
- ready  out  1  high when both resets are released.
- loss_count  out  LOSS_CNT_W  saturating count of lock-loss events.

Behaviour:
- Reset is asynchronous and active-low (reset_n).
- Reset values: core_reset_n=0, panel_reset_n=0, ready=0, loss_count=0, synchroniser flops=0, state=WAIT_LOCK, counters=0.
- Synchroniser: two flops on locked; lock_s = second flop output. A rise on locked appears on lock_s 2 cycles later. No other logic samples locked directly.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - WAIT_LOCK: both resets 0, ready 0. Counter cleared. lock_s=1 -> STABLE.
  - STABLE: counter increments each cycle with lock_s=1. When counter reaches LOCK_STABLE_CYCLES-1 -> CORE_UP, and core_reset_n=1 from the next cycle.
  - CORE_UP: core_reset_n=1, panel_reset_n=0. Counts STAGE_DELAY cycles -> PANEL_UP.
  - PANEL_UP: both resets 1. Moves to RUN after 1 cycle; ready=1 from entry to RUN.
  - RUN: all outputs high; holds while lock_s=1.
- Timing: if lock_s first goes high at cycle S and stays high:
  - core_reset_n rises at S+LOCK_STABLE_CYCLES.
  - panel_reset_n rises at S+LOCK_STABLE_CYCLES+STAGE_DELAY.
  - ready rises 1 cycle after panel_reset_n.
- Loss of lock: lock_s=0 in any state other than WAIT_LOCK -> WAIT_LOCK. On the next edge, core_reset_n, panel_reset_n and ready all go 0 together, and the counter is cleared.
  - A glitch in STABLE restarts qualification from zero; no partial credit.
- loss_count:
  - Increments by 1 on each lock_s=0 exit from STABLE, CORE_UP, PANEL_UP or RUN.
  - Saturates at all-ones.
  - clear_loss alone sets it to 0.
  - clear_loss coincident with a loss event sets it to 1.
- reset_n asserted mid-sequence returns every output to its reset value immediately (asynchronous). After release, sequencing restarts from WAIT_LOCK with the full qualification delay.
- locked held permanently high through reset_n release: the first lock_s is seen at cycle 2 after release, and the normal sequence follows.

Optional Feature:
- Macro: PLL_RESET_SEQ_WATCHDOG_EN.
- With the macro defined:
  - Adds parameter WATCHDOG_CYCLES (default 1_000_000) and output port pll_restart (1 bit, reset value 0).
  - In WAIT_LOCK, a watchdog counter increments each cycle.
  - On reaching WATCHDOG_CYCLES-1 without lock_s, pll_restart is driven 1 for exactly 16 cycles, then the watchdog counter restarts from 0.
  - pll_restart is intended to drive the PLL RST input.
  - The watchdog is cleared and disabled outside WAIT_LOCK.
  - A restart does not increment loss_count.
- Without the macro: the pll_restart port and the watchdog logic are absent, and WAIT_LOCK waits indefinitely.

Test Plan:
- LOCK_STABLE_CYCLES=8, STAGE_DELAY=4; locked rises at cycle 10 after reset -> lock_s at 12, core_reset_n at 20, panel_reset_n at 24, ready at 25; loss_count=0.
- Same parameters; locked high, then a 1-cycle low pulse during STABLE at cycle 16 -> no release until 8 new consecutive lock_s cycles; core_reset_n at 26 or later; loss_count=1.
- In RUN, drop locked -> 3 cycles later (2 sync + 1 register) all three outputs read 0; loss_count increments; re-lock repeats the full 8+4 sequence.
- LOSS_CNT_W=2; five loss events -> loss_count=3 (saturated); clear_loss coincident with a sixth event -> loss_count=1.
- Assert reset_n while in CORE_UP -> core_reset_n=0 asynchronously, before the next edge; with locked still high, release restarts with core_reset_n at release+2+8.
- With PLL_RESET_SEQ_WATCHDOG_EN and WATCHDOG_CYCLES=50, locked held low -> pll_restart high for cycles 50..65 after reset release; next pulse at 50 cycles after the end of the first (cycle 116); pll_restart never rises once lock_s=1.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - lock input and staged reset outputs of pll_reset_sequencer
// PLL_RESET_SEQ_WATCHDOG_EN adds the pll_restart signal.
interface pll_reset_sequencer_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  locked;
  logic                  clear_loss;
  logic                  core_reset_n;
  logic                  panel_reset_n;
  logic                  ready;
  logic [LOSS_CNT_W-1:0] loss_count;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
  logic                  pll_restart;
`endif

  modport master (
    input  locked,
    input  clear_loss,
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    output pll_restart,
`endif
    output core_reset_n,
    output panel_reset_n,
    output ready,
    output loss_count
  );

  modport slave (
    output locked,
    output clear_loss,
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    input  pll_restart,
`endif
    input  core_reset_n,
    input  panel_reset_n,
    input  ready,
    input  loss_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - qualifies PLL lock and releases core then panel resets
// PLL_RESET_SEQ_WATCHDOG_EN adds a WAIT_LOCK watchdog driving pll_restart.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 16,
  parameter int LOSS_CNT_W         = 8
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
  , parameter int WATCHDOG_CYCLES  = 1_000_000
`endif
) (
  input logic                   clock,
  input logic                   reset_n,
  pll_reset_sequencer_if.master bus
);

  localparam logic [2:0] WAIT_LOCK = 3'd0;
  localparam logic [2:0] STABLE    = 3'd1;
  localparam logic [2:0] CORE_UP   = 3'd2;
  localparam logic [2:0] PANEL_UP  = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic                  lock_meta_q, lock_meta_d;
  logic                  lock_s_q, lock_s_d;
  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  core_q, core_d;
  logic                  panel_q, panel_d;
  logic                  ready_q, ready_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  loss_event;

  always_comb begin
    lock_meta_d = bus.locked;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    loss_event  = 1'b0;
    if (state_q != WAIT_LOCK && !lock_s_q) begin
      // Any drop after qualification began throws away all progress.
      state_d    = WAIT_LOCK;
      cnt_d      = '0;
      loss_event = 1'b1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          cnt_d = '0;
          if (lock_s_q) begin
            if (LOCK_STABLE_CYCLES == 1) begin
              state_d = CORE_UP;
            end else begin
              state_d = STABLE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        STABLE: begin
          if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_d = CORE_UP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        CORE_UP: begin
          if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
            state_d = PANEL_UP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PANEL_UP: state_d = RUN;
        RUN:      state_d = RUN;
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the next state so they change on the transition edge.
    core_d  = (state_d == CORE_UP) || (state_d == PANEL_UP) || (state_d == RUN);
    panel_d = (state_d == PANEL_UP) || (state_d == RUN);
    ready_d = (state_d == RUN);

    loss_d = loss_q;
    if (bus.clear_loss) begin
      loss_d = loss_event ? LOSS_CNT_W'(1) : '0;
    end else if (loss_event && loss_q != '1) begin
      loss_d = loss_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      core_q      <= 1'b0;
      panel_q     <= 1'b0;
      ready_q     <= 1'b0;
      loss_q      <= '0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_q      <= core_d;
      panel_q     <= panel_d;
      ready_q     <= ready_d;
      loss_q      <= loss_d;
    end
  end

  assign bus.core_reset_n  = core_q;
  assign bus.panel_reset_n = panel_q;
  assign bus.ready         = ready_q;
  assign bus.loss_count    = loss_q;

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [3:0]      pulse_cnt_q, pulse_cnt_d;
  logic            restart_q, restart_d;

  always_comb begin
    wd_cnt_d    = wd_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    restart_d   = restart_q;
    if (state_q != WAIT_LOCK || lock_s_q) begin
      wd_cnt_d    = '0;
      pulse_cnt_d = '0;
      restart_d   = 1'b0;
    end else if (restart_q) begin
      // Pulse lasts 16 cycles; the timeout period restarts when it ends.
      if (pulse_cnt_q == 4'd15) begin
        restart_d   = 1'b0;
        pulse_cnt_d = '0;
        wd_cnt_d    = '0;
      end else begin
        pulse_cnt_d = pulse_cnt_q + 1'b1;
      end
    end else if (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1)) begin
      restart_d   = 1'b1;
      pulse_cnt_d = '0;
      wd_cnt_d    = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q    <= '0;
      pulse_cnt_q <= '0;
      restart_q   <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      restart_q   <= restart_d;
    end
  end

  assign bus.pll_restart = restart_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed bench for pll_reset_sequencer (L=8, D=4, W=2)
// PLL_RESET_SEQ_WATCHDOG_EN also exercises the watchdog with WATCHDOG_CYCLES=50.
module tb_pll_reset_sequencer;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;

  pll_reset_sequencer_if #(.LOSS_CNT_W(2)) bus ();

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .STAGE_DELAY(4),
    .LOSS_CNT_W(2),
    .WATCHDOG_CYCLES(50)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
`else
  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .STAGE_DELAY(4),
    .LOSS_CNT_W(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
`endif

  initial clock = 1'b0;
  always #4 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  // Cycle 0 is the point just after the release edge.
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    reset_n        = 1'b1;
    bus.locked     = 1'b0;
    bus.clear_loss = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_core",  32'(bus.core_reset_n),  32'd0);
    check("rst_panel", 32'(bus.panel_reset_n), 32'd0);
    check("rst_ready", 32'(bus.ready),         32'd0);
    check("rst_loss",  32'(bus.loss_count),    32'd0);

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    do_reset();
    check("wd_rst", 32'(bus.pll_restart), 32'd0);
    tick_to(49);  check("wd_49",  32'(bus.pll_restart), 32'd0);
    tick_to(50);  check("wd_50",  32'(bus.pll_restart), 32'd1);
    tick_to(65);  check("wd_65",  32'(bus.pll_restart), 32'd1);
    tick_to(66);  check("wd_66",  32'(bus.pll_restart), 32'd0);
    tick_to(115); check("wd_115", 32'(bus.pll_restart), 32'd0);
    tick_to(116); check("wd_116", 32'(bus.pll_restart), 32'd1);
    bus.locked = 1'b1;
    tick_to(240);
    check("wd_locked", 32'(bus.pll_restart), 32'd0);
    check("wd_loss",   32'(bus.loss_count),  32'd0);
    bus.locked = 1'b0;
`endif

    // Clean lock: lock_s at 12, core 20, panel 24, ready 25.
    do_reset();
    tick_to(10);
    bus.locked = 1'b1;
    tick_to(19); check("t1_core19",  32'(bus.core_reset_n),  32'd0);
    tick_to(20); check("t1_core20",  32'(bus.core_reset_n),  32'd1);
                 check("t1_panel20", 32'(bus.panel_reset_n), 32'd0);
    tick_to(23); check("t1_panel23", 32'(bus.panel_reset_n), 32'd0);
    tick_to(24); check("t1_panel24", 32'(bus.panel_reset_n), 32'd1);
                 check("t1_ready24", 32'(bus.ready),         32'd0);
    tick_to(25); check("t1_ready25", 32'(bus.ready),         32'd1);
                 check("t1_loss",    32'(bus.loss_count),    32'd0);

    // Loss in RUN: outputs drop 3 cycles after locked falls, then full re-qualification.
    tick_to(30);
    bus.locked = 1'b0;
    tick_to(32); check("t3_core32",  32'(bus.core_reset_n),  32'd1);
    tick_to(33); check("t3_core33",  32'(bus.core_reset_n),  32'd0);
                 check("t3_panel33", 32'(bus.panel_reset_n), 32'd0);
                 check("t3_ready33", 32'(bus.ready),         32'd0);
                 check("t3_loss33",  32'(bus.loss_count),    32'd1);
    tick_to(40);
    bus.locked = 1'b1;
    tick_to(49); check("t3_core49",  32'(bus.core_reset_n),  32'd0);
    tick_to(50); check("t3_core50",  32'(bus.core_reset_n),  32'd1);
    tick_to(53); check("t3_panel53", 32'(bus.panel_reset_n), 32'd0);
    tick_to(54); check("t3_panel54", 32'(bus.panel_reset_n), 32'd1);
    tick_to(55); check("t3_ready55", 32'(bus.ready),         32'd1);

    // Glitch in STABLE at cycle 16: qualification restarts, core no earlier than 26.
    bus.locked = 1'b0;
    do_reset();
    check("t2_loss0", 32'(bus.loss_count), 32'd0);
    tick_to(10); bus.locked = 1'b1;
    tick_to(16); bus.locked = 1'b0;
    tick_to(17); bus.locked = 1'b1;
    tick_to(20); check("t2_core20", 32'(bus.core_reset_n), 32'd0);
    tick_to(26); check("t2_core26", 32'(bus.core_reset_n), 32'd0);
    tick_to(27); check("t2_core27", 32'(bus.core_reset_n), 32'd1);
                 check("t2_loss27", 32'(bus.loss_count),   32'd1);

    // Four more loss events saturate the 2-bit counter at 3.
    tick_to(28);
    for (int i = 0; i < 4; i++) begin
      bus.locked = 1'b0;
      tick_to(cyc + 1);
      bus.locked = 1'b1;
      tick_to(cyc + 3);
      check("t4_loss_sat", 32'(bus.loss_count), (i + 2 > 3) ? 32'd3 : 32'(i + 2));
    end

    // clear_loss coincident with a sixth event leaves 1; alone it leaves 0.
    bus.locked = 1'b0;
    tick_to(cyc + 1);
    bus.locked = 1'b1;
    tick_to(cyc + 1);
    bus.clear_loss = 1'b1;
    tick_to(cyc + 1);
    bus.clear_loss = 1'b0;
    check("t4_clear_evt", 32'(bus.loss_count), 32'd1);
    tick_to(cyc + 3);
    bus.clear_loss = 1'b1;
    tick_to(cyc + 1);
    bus.clear_loss = 1'b0;
    check("t4_clear", 32'(bus.loss_count), 32'd0);

    // Async reset in CORE_UP with locked held high; restart gives core at release+10.
    do_reset();
    tick_to(10); check("t5_core10", 32'(bus.core_reset_n), 32'd1);
    tick_to(12);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_core",  32'(bus.core_reset_n),  32'd0);
    check("t5_async_panel", 32'(bus.panel_reset_n), 32'd0);
    do_reset();
    tick_to(9);  check("t5_core9",   32'(bus.core_reset_n),  32'd0);
    tick_to(10); check("t5_core10b", 32'(bus.core_reset_n),  32'd1);
    tick_to(13); check("t5_panel13", 32'(bus.panel_reset_n), 32'd0);
    tick_to(14); check("t5_panel14", 32'(bus.panel_reset_n), 32'd1);
    tick_to(15); check("t5_ready15", 32'(bus.ready),         32'd1);
                 check("t5_loss",    32'(bus.loss_count),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
